// File: rtl/risk_check_scheduler.sv
// risk_check_scheduler: shares one risk check engine between NUM_REQ requesters.
// Round-robin grant, one check in flight, verdict routed back to the requester.
// Optional watchdog on the engine wait: define RISK_SCHED_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no check in flight; arbitrate and accept one request
// ST_ISSUE | one-cycle chk_valid strobe to the engine
// ST_WAIT  | waiting for chk_done (or watchdog expiry when enabled)
// ST_RESP  | one-cycle verdict strobe to the originating requester
module risk_check_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic                 resp_approved,
  input  logic                 halt,
  output logic                 chk_valid,
  output logic [31:0]          chk_data,
  input  logic                 chk_done,
  input  logic                 chk_approved,
  output logic                 busy,
  output logic [15:0]          approved_cnt,
  output logic [15:0]          rejected_cnt,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("risk_check_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [31:0]   data_q, data_d;
  logic          verdict_q, verdict_d;
  logic [15:0]   appr_cnt_q, appr_cnt_d;
  logic [15:0]   rej_cnt_q, rej_cnt_d;
`ifdef RISK_SCHED_TIMEOUT_EN
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic          to_err_q, to_err_d;
`endif

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   scan;
  logic [IW-1:0] scan_idx;
  logic [31:0]   grant_data;
  logic          grant_ok;

  // Round-robin search starting at rr_ptr, plus the granted requester's data.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    scan_idx    = '0;
    grant_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      scan_idx = scan[IW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IW'(k)) grant_data = req_data[32*k +: 32];
    end
  end

  assign grant_ok = rst_n && (state_q == ST_IDLE) && !halt && grant_found;

  // Next-state logic for the request/check/response sequence.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    data_d     = data_q;
    verdict_d  = verdict_q;
    appr_cnt_d = appr_cnt_q;
    rej_cnt_d  = rej_cnt_q;
`ifdef RISK_SCHED_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    to_err_d   = to_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          state_d  = ST_ISSUE;
          id_d     = grant_idx;
          data_d   = grant_data;
          rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef RISK_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (chk_done) begin
          verdict_d = chk_approved;
          state_d   = ST_RESP;
        end
`ifdef RISK_SCHED_TIMEOUT_EN
        // Engine silence on the last allowed cycle forces a reject.
        else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          verdict_d = 1'b0;
          to_err_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        if (verdict_q) begin
          if (appr_cnt_q != 16'hFFFF) appr_cnt_d = appr_cnt_q + 16'd1;
        end else begin
          if (rej_cnt_q != 16'hFFFF) rej_cnt_d = rej_cnt_q + 16'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      verdict_q  <= 1'b0;
      appr_cnt_q <= '0;
      rej_cnt_q  <= '0;
`ifdef RISK_SCHED_TIMEOUT_EN
      wait_cnt_q <= '0;
      to_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      data_q     <= data_d;
      verdict_q  <= verdict_d;
      appr_cnt_q <= appr_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
`ifdef RISK_SCHED_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      to_err_q   <= to_err_d;
`endif
    end
  end

  // Output decode: grant and verdict strobes are one-hot on the requester index.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k]  = grant_ok && (grant_idx == IW'(k));
      resp_valid[k] = (state_q == ST_RESP) && (id_q == IW'(k));
    end
  end

  assign resp_approved = (state_q == ST_RESP) && verdict_q;
  assign chk_valid     = (state_q == ST_ISSUE);
  assign chk_data      = data_q;
  assign busy          = (state_q != ST_IDLE);
  assign approved_cnt  = appr_cnt_q;
  assign rejected_cnt  = rej_cnt_q;
`ifdef RISK_SCHED_TIMEOUT_EN
  assign timeout_err   = to_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_risk_check_scheduler.sv
// Bench for risk_check_scheduler (NUM_REQ=4). Honours RISK_SCHED_TIMEOUT_EN.
module tb_risk_check_scheduler;

  localparam int TOC = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic         resp_approved;
  logic         halt;
  logic         chk_valid;
  logic [31:0]  chk_data;
  logic         chk_done;
  logic         chk_approved;
  logic         busy;
  logic [15:0]  approved_cnt;
  logic [15:0]  rejected_cnt;
  logic         timeout_err;

  risk_check_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_approved(resp_approved),
    .halt(halt), .chk_valid(chk_valid), .chk_data(chk_data), .chk_done(chk_done),
    .chk_approved(chk_approved), .busy(busy), .approved_cnt(approved_cnt),
    .rejected_cnt(rejected_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] data_arr [4];

  // reference model state
  int          ptr_m = 0;
  int          appr_m = 0;
  int          rej_m = 0;
  bit          to_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  // Entered at a negedge with the DUT idle; returns at the idle negedge after RESP.
  // d: number of silent WAIT cycles before chk_done (-1 = engine never answers).
  task automatic do_round(input logic [3:0] v, input int d, input bit a, input bit keep,
                          input bit spur, input bit hlt, input bit fix100);
    int g;
    int wc;
    bit fa;
    bit tof;
    for (int i = 0; i < 4; i++) data_arr[i] = $urandom;
    if (fix100) data_arr[0] = 32'd100;
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = data_arr[i];
    req_valid = v;
    chk_done  = 1'b0;
    #1;
    g = rr_pick(v);
    check_eq("grant", {28'd0, req_ready}, 32'd1 << g);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
    ptr_m = (g + 1) % 4;

    @(negedge clk);
    if (!keep) req_valid[g] = 1'b0;
    chk_done     = spur;
    chk_approved = ~a;
    #1;
    check_eq("chk_valid", {31'd0, chk_valid}, 32'd1);
    check_eq("chk_data", chk_data, data_arr[g]);
    check_eq("ready_issue", {28'd0, req_ready}, 32'd0);

    wc  = d + 1;
    fa  = a;
    tof = 1'b0;
`ifdef RISK_SCHED_TIMEOUT_EN
    if (d < 0 || d + 1 > TOC) begin
      wc  = TOC;
      fa  = 1'b0;
      tof = 1'b1;
    end
`endif
    for (int c = 1; c <= wc; c++) begin
      @(negedge clk);
      chk_done     = (c == d + 1);
      chk_approved = a;
      if (hlt && c == 1) begin
        halt      = 1'b1;
        req_valid = 4'b0110;
      end
      #1;
      check_eq("no_resp_wait", {28'd0, resp_valid}, 32'd0);
      check_eq("ready_wait", {28'd0, req_ready}, 32'd0);
    end

    @(negedge clk);
    chk_done = 1'b0;
    #1;
    check_eq("resp_valid", {28'd0, resp_valid}, 32'd1 << g);
    check_eq("resp_approved", {31'd0, resp_approved}, {31'd0, fa});
    if (fa) begin
      if (appr_m < 65535) appr_m++;
    end else begin
      if (rej_m < 65535) rej_m++;
    end
    to_m = to_m | tof;

    @(negedge clk);
    #1;
    check_eq("resp_clear", {28'd0, resp_valid}, 32'd0);
    check_eq("approved_cnt", {16'd0, approved_cnt}, appr_m);
    check_eq("rejected_cnt", {16'd0, rejected_cnt}, rej_m);
    check_eq("timeout_err", {31'd0, timeout_err}, {31'd0, to_m});
    if (hlt) check_eq("ready_halt", {28'd0, req_ready}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'b1111;
    req_data     = '0;
    halt         = 1'b0;
    chk_done     = 1'b0;
    chk_approved = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_resp", {28'd0, resp_valid}, 32'd0);
    check_eq("rst_chk_valid", {31'd0, chk_valid}, 32'd0);
    check_eq("rst_chk_data", chk_data, 32'd0);
    check_eq("rst_cnts", {approved_cnt, rejected_cnt}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout_err}, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // single requester, fastest engine answer
    do_round(4'b0001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of WAIT; a late chk_done must be ignored
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    chk_done     = 1'b1;
    chk_approved = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_resp", {28'd0, resp_valid}, 32'd0);
    check_eq("midrst_cnts", {approved_cnt, rejected_cnt}, 32'd0);
    @(negedge clk);
    chk_done = 1'b0;
    #1;
    check_eq("late_done_resp", {28'd0, resp_valid}, 32'd0);
    check_eq("late_done_busy", {31'd0, busy}, 32'd0);
    ptr_m  = 0;
    appr_m = 0;
    rej_m  = 0;
    to_m   = 1'b0;

    // all requesters held valid: rotation 0,1,2,3,0
    for (int r = 0; r < 5; r++)
      do_round(4'b1111, $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);

    // halt raised during WAIT with 0110 pending
    do_round(4'b0001, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check_eq("halt_ready", {28'd0, req_ready}, 32'd0);
      check_eq("halt_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    halt = 1'b0;
    do_round(4'b0110, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic, verdicts, dropped requesters, stray chk_done in ISSUE
    for (int r = 0; r < 40; r++)
      do_round(4'($urandom_range(1, 15)), $urandom_range(0, 8), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

`ifdef RISK_SCHED_TIMEOUT_EN
    do_round(4'b0001, TOC - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_round(4'b0010, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_round(4'b0100, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    do_round(4'b0100, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
